// File: rtl/ps2_sb_pkg.sv
// ps2_sb_pkg
//   Shared definitions for the PS/2 scan-code FIFO slave block: register byte
//   offsets, STATUS bit positions, the FLUSH key and an offset decoder.
package ps2_sb_pkg;

  // Register byte offsets inside the block's address window.
  localparam logic [7:0] OFF_DATA   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;
  localparam logic [7:0] OFF_THRESH = 8'h0C;
  localparam logic [7:0] OFF_FLUSH  = 8'h24;

  // STATUS register bit positions.
  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_COUNT_LSB = 8;

  // Value that must be written to FLUSH to empty the FIFO.
  localparam logic [31:0] FLUSH_KEY = 32'h0000_0001;

  typedef enum logic [2:0] {
    REG_DATA,
    REG_STATUS,
    REG_CTRL,
    REG_THRESH,
    REG_FLUSH,
    REG_NONE
  } reg_sel_e;

  // Map a full bus address to a register; anything outside the first
  // 256 bytes or not on a defined offset is unmapped.
  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    reg_sel_e sel;
    sel = REG_NONE;
    if (addr[31:8] == 24'h0) begin
      case (addr[7:0])
        OFF_DATA:   sel = REG_DATA;
        OFF_STATUS: sel = REG_STATUS;
        OFF_CTRL:   sel = REG_CTRL;
        OFF_THRESH: sel = REG_THRESH;
        OFF_FLUSH:  sel = REG_FLUSH;
        default:    sel = REG_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/PS2Receiver.sv
// PS2Receiver
//   Receives 11-bit PS/2 device-to-host frames (start, 8 data LSB first,
//   odd parity, stop) and emits each valid byte with a one-cycle pulse.
// Ports:
//   clk_i, rst_i      system clock, synchronous active-high reset
//   kclk_i, kdata_i   asynchronous PS/2 clock and data lines
//   keycode_o         last received byte
//   keycode_valid_o   one-cycle pulse when keycode_o holds a new good byte
module PS2Receiver (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       kclk_i,
  input  logic       kdata_i,
  output logic [7:0] keycode_o,
  output logic       keycode_valid_o
);

  logic [2:0]  kclk_sync;
  logic [1:0]  kdata_sync;
  logic [10:0] shreg;
  logic [3:0]  bit_cnt;
  logic        kclk_fall;
  logic [10:0] frame_next;

  // Device changes data while clock is high; sample on the falling edge.
  assign kclk_fall  = kclk_sync[2] & ~kclk_sync[1];
  assign frame_next = {kdata_sync[1], shreg[10:1]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      kclk_sync       <= '1;
      kdata_sync      <= '1;
      shreg           <= '0;
      bit_cnt         <= '0;
      keycode_o       <= '0;
      keycode_valid_o <= 1'b0;
    end else begin
      kclk_sync       <= {kclk_sync[1:0], kclk_i};
      kdata_sync      <= {kdata_sync[0], kdata_i};
      keycode_valid_o <= 1'b0;
      if (kclk_fall) begin
        shreg <= frame_next;
        if (bit_cnt == 4'd10) begin
          bit_cnt         <= '0;
          keycode_o       <= frame_next[8:1];
          // start low, stop high, odd parity over data+parity
          keycode_valid_o <= ~frame_next[0] & frame_next[10] & (^frame_next[9:1]);
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/sb_sync_fifo.sv
// sb_sync_fifo
//   Single-clock FIFO with flush. A push is accepted when not full or when a
//   pop happens in the same cycle; pops on an empty FIFO are ignored. Flush
//   wins over push and pop.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   flush_i        empty the FIFO and reset pointers
//   push_i/_data_i write request and data
//   pop_i          read request (head_o is the entry removed)
//   head_o         current head entry (combinational)
//   count_o        number of stored entries, 0..DEPTH
//   full_o/empty_o occupancy flags
module sb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_o == CW'(DEPTH));
  assign empty_o = (count_o == '0);
  assign head_o  = mem[rd_ptr];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // NOTE: storage has no reset; the pointers and count alone define which
  // entries are valid, so resetting the array would only cost logic.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem[wr_ptr] <= push_data_i;
    end
  end

  // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
  // modulo DEPTH by plain overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_o <= count_o + CW'(1);
        2'b01:   count_o <= count_o - CW'(1);
        default: count_o <= count_o;
      endcase
    end
  end

endmodule

// File: rtl/ps2_fifo_sb_ctrl.sv
// ps2_fifo_sb_ctrl
//   Bus slave that queues PS/2 scan codes in a FIFO and raises an interrupt
//   when enough codes are waiting.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   addr_i, req_i         bus byte address and request
//   write_enable_i        1 = write, 0 = read
//   write_data_i          write data
//   read_data_o           read data, registered, valid the cycle after a read
//   interrupt_request_o   registered interrupt request
//   interrupt_return_i    one-cycle pulse when the core returns from the ISR
//   kclk_i, kdata_i       PS/2 clock and data lines
module ps2_fifo_sb_ctrl
  import ps2_sb_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int IRQ_THRESH_RST = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic        req_i,
  input  logic        write_enable_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        interrupt_request_o,
  input  logic        interrupt_return_i,
  input  logic        kclk_i,
  input  logic        kdata_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          rx_valid;
  logic [7:0]    rx_code;
  reg_sel_e      sel;
  logic          bus_rd;
  logic          bus_wr;
  logic          pop;
  logic          flush;
  logic          push_ok;
  logic          push_drop;
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          serviced;
  logic          irq_en;
  logic [7:0]    thresh;
  logic [8:0]    count_ext;
  logic [8:0]    thresh_eff;
  logic          pending;
  logic [31:0]   rd_mux;

  PS2Receiver u_rx (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .kclk_i          (kclk_i),
    .kdata_i         (kdata_i),
    .keycode_o       (rx_code),
    .keycode_valid_o (rx_valid)
  );

  assign sel    = decode_addr(addr_i);
  assign bus_rd = req_i & ~write_enable_i;
  assign bus_wr = req_i & write_enable_i;
  assign pop    = bus_rd && (sel == REG_DATA) && !empty;
  assign flush  = bus_wr && (sel == REG_FLUSH) && (write_data_i == FLUSH_KEY);

  // A full FIFO still takes a push when a pop frees a slot in the same cycle.
  assign push_ok   = rx_valid && !flush && (!full || pop);
  assign push_drop = rx_valid && !flush && full && !pop;

  sb_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush),
    .push_i      (rx_valid),
    .push_data_i (rx_code),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

  // THRESH of 0 behaves like 1 so an enabled interrupt can never fire on an
  // empty FIFO.
  assign count_ext  = 9'(count);
  assign thresh_eff = (thresh == 8'h00) ? 9'd1 : {1'b0, thresh};
  assign pending    = irq_en && (count_ext >= thresh_eff) && !serviced;

  always_comb begin
    // NOTE: every path starts from a default so no latch is inferred and
    // unmapped or write-only offsets read as zero.
    rd_mux = '0;
    case (sel)
      REG_DATA:   rd_mux = empty ? 32'h0 : {24'h0, head};
      REG_STATUS: begin
        rd_mux[STAT_NOT_EMPTY]                = ~empty;
        rd_mux[STAT_FULL]                     = full;
        rd_mux[STAT_OVERFLOW]                 = overflow;
        rd_mux[STAT_COUNT_LSB +: 8]           = 8'(count);
      end
      REG_CTRL:   rd_mux = {31'h0, irq_en};
      REG_THRESH: rd_mux = {24'h0, thresh};
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      read_data_o         <= '0;
      interrupt_request_o <= 1'b0;
      overflow            <= 1'b0;
      serviced            <= 1'b0;
      irq_en              <= 1'b0;
      thresh              <= 8'(IRQ_THRESH_RST);
    end else begin
      if (bus_rd) read_data_o <= rd_mux;

      if (bus_wr && sel == REG_CTRL)   irq_en <= write_data_i[0];
      if (bus_wr && sel == REG_THRESH) thresh <= write_data_i[7:0];

      if (flush)          overflow <= 1'b0;
      else if (push_drop) overflow <= 1'b1;

      // A new code or a flush re-arms the interrupt even if the core is
      // returning from the handler in the same cycle.
      if (push_ok || flush)         serviced <= 1'b0;
      else if (interrupt_return_i)  serviced <= 1'b1;

      interrupt_request_o <= pending;
    end
  end

endmodule

// File: tb/tb_ps2_fifo_sb_ctrl.sv
// tb_ps2_fifo_sb_ctrl
//   Randomised and directed stimulus for ps2_fifo_sb_ctrl. A queue-based
//   reference model predicts every read; expected read data goes into a
//   scoreboard queue that a separate monitor drains.
module tb_ps2_fifo_sb_ctrl;

  localparam int DEPTH   = 4;
  localparam int THR_RST = 2;

  typedef enum {ACT_NONE, ACT_READ, ACT_FLUSH, ACT_RESET, ACT_IRET} act_e;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] addr_i = '0;
  logic        req_i = 1'b0;
  logic        write_enable_i = 1'b0;
  logic [31:0] write_data_i = '0;
  logic [31:0] read_data_o;
  logic        interrupt_request_o;
  logic        interrupt_return_i = 1'b0;
  logic        kclk_i = 1'b1;
  logic        kdata_i = 1'b1;

  always #5 clk_i = ~clk_i;

  ps2_fifo_sb_ctrl #(
    .FIFO_DEPTH     (DEPTH),
    .IRQ_THRESH_RST (THR_RST)
  ) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .addr_i              (addr_i),
    .req_i               (req_i),
    .write_enable_i      (write_enable_i),
    .write_data_i        (write_data_i),
    .read_data_o         (read_data_o),
    .interrupt_request_o (interrupt_request_o),
    .interrupt_return_i  (interrupt_return_i),
    .kclk_i              (kclk_i),
    .kdata_i             (kdata_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  fifo_m[$];
  logic        ovf_m = 1'b0;
  logic        irq_en_m = 1'b0;
  logic        serviced_m = 1'b0;
  logic [7:0]  thr_m = 8'(THR_RST);
  logic [31:0] exp_q[$];

  function automatic logic pending_m();
    int t;
    t = (thr_m == 8'h00) ? 1 : int'(thr_m);
    return irq_en_m && (fifo_m.size() >= t) && !serviced_m;
  endfunction

  function automatic void model_reset();
    fifo_m.delete();
    ovf_m = 1'b0; irq_en_m = 1'b0; serviced_m = 1'b0; thr_m = 8'(THR_RST);
  endfunction

  function automatic void model_push(input logic [7:0] c);
    if (fifo_m.size() < DEPTH) begin
      fifo_m.push_back(c);
      serviced_m = 1'b0;
    end else begin
      ovf_m = 1'b1;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] off);
    logic [31:0] r;
    r = '0;
    case (off)
      8'h00: if (fifo_m.size() > 0) r = {24'h0, fifo_m.pop_front()};
      8'h04: r = {16'h0, 8'(fifo_m.size()), 5'h0, ovf_m,
                  (fifo_m.size() == DEPTH), (fifo_m.size() != 0)};
      8'h08: r = {31'h0, irq_en_m};
      8'h0C: r = {24'h0, thr_m};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic void model_write(input logic [7:0] off, input logic [31:0] d);
    case (off)
      8'h08: irq_en_m = d[0];
      8'h0C: thr_m = d[7:0];
      8'h24: if (d == 32'h1) begin
        fifo_m.delete(); ovf_m = 1'b0; serviced_m = 1'b0;
      end
      default: ;
    endcase
  endfunction

  // ---------------- monitor ----------------
  logic        rd_d = 1'b0;
  logic        rst_d = 1'b1;
  logic [31:0] hold_exp = '0;

  always @(posedge clk_i) begin
    rd_d  <= req_i && !write_enable_i && !rst_i;
    rst_d <= rst_i;
  end

  always @(negedge clk_i) begin
    if (rst_d) begin
      hold_exp = '0;
    end else if (rd_d) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL read_scoreboard: got 0x%08h with no expected entry", read_data_o);
      end else begin
        hold_exp = exp_q.pop_front();
      end
    end
    check("read_data", read_data_o, hold_exp);
  end

  // ---------------- stimulus tasks (enter and leave on a negedge) ----------------
  task automatic bus_read(input logic [7:0] off);
    req_i = 1'b1; write_enable_i = 1'b0; addr_i = {24'h0, off};
    exp_q.push_back(model_read(off));
    @(negedge clk_i);
    req_i = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] off, input logic [31:0] d);
    req_i = 1'b1; write_enable_i = 1'b1; addr_i = {24'h0, off}; write_data_i = d;
    model_write(off, d);
    @(negedge clk_i);
    req_i = 1'b0; write_enable_i = 1'b0;
  endtask

  task automatic settle_check();
    @(negedge clk_i);
    check("irq_settled", {31'h0, interrupt_request_o}, {31'h0, pending_m()});
  endtask

  task automatic pulse_iret();
    interrupt_return_i = 1'b1;
    serviced_m = 1'b1;
    @(negedge clk_i);
    interrupt_return_i = 1'b0;
    @(negedge clk_i);
    check("irq_after_return", {31'h0, interrupt_request_o}, {31'h0, pending_m()});
  endtask

  // Sends one frame; in the cycle the receiver presents the code, performs
  // the requested coincident action.
  task automatic send_frame(input logic [7:0] code, input act_e act);
    logic [10:0] f;
    logic        p_before;
    int          w;
    f = {1'b1, ~^code, code, 1'b0};
    for (int i = 0; i < 11; i++) begin
      kdata_i = f[i];
      repeat (2) @(negedge clk_i);
      kclk_i = 1'b0;
      if (i < 10) begin
        repeat (3) @(negedge clk_i);
        kclk_i = 1'b1;
        repeat (2) @(negedge clk_i);
      end
    end
    w = 0;
    while (dut.rx_valid !== 1'b1 && w < 20) begin
      @(negedge clk_i);
      w++;
    end
    check("rx_frame_seen", {31'h0, dut.rx_valid}, 32'h1);
    p_before = pending_m();
    case (act)
      ACT_READ: begin
        req_i = 1'b1; write_enable_i = 1'b0; addr_i = 32'h0;
        exp_q.push_back(model_read(8'h00));
        model_push(code);
      end
      ACT_FLUSH: begin
        req_i = 1'b1; write_enable_i = 1'b1; addr_i = 32'h24; write_data_i = 32'h1;
        model_write(8'h24, 32'h1);
      end
      ACT_RESET: begin
        rst_i = 1'b1;
        model_reset();
      end
      ACT_IRET: begin
        interrupt_return_i = 1'b1;
        serviced_m = 1'b1;
        model_push(code);
      end
      default: model_push(code);
    endcase
    @(negedge clk_i);
    req_i = 1'b0; write_enable_i = 1'b0; rst_i = 1'b0; interrupt_return_i = 1'b0;
    kclk_i = 1'b1; kdata_i = 1'b1;
    check("irq_latency_old", {31'h0, interrupt_request_o},
          {31'h0, (act == ACT_RESET) ? 1'b0 : p_before});
    @(negedge clk_i);
    check("irq_latency_new", {31'h0, interrupt_request_o}, {31'h0, pending_m()});
    repeat (2) @(negedge clk_i);
  endtask

  // ---------------- test sequence ----------------
  logic [7:0] offs [10];
  logic [7:0] codes5 [5];

  initial begin
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h24, 8'h10, 8'h14, 8'h20, 8'h28, 8'h3C};
    codes5 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};

    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    check("irq_reset", {31'h0, interrupt_request_o}, 32'h0);
    bus_read(8'h04);
    bus_read(8'h0C);
    bus_read(8'h08);

    // Ordered delivery and empty read.
    send_frame(8'h1C, ACT_NONE);
    send_frame(8'h32, ACT_NONE);
    send_frame(8'h21, ACT_NONE);
    repeat (4) bus_read(8'h00);
    bus_read(8'h04);

    // Overflow on a full FIFO.
    for (int i = 0; i < 5; i++) send_frame(codes5[i], ACT_NONE);
    bus_read(8'h04);
    repeat (4) bus_read(8'h00);
    bus_read(8'h04);
    bus_write(8'h24, 32'h1);
    bus_read(8'h04);

    // Threshold interrupt with return and re-arm.
    bus_write(8'h08, 32'h1);
    bus_write(8'h0C, 32'h3);
    send_frame(8'h11, ACT_NONE);
    send_frame(8'h22, ACT_NONE);
    check("irq_below_thresh", {31'h0, interrupt_request_o}, 32'h0);
    send_frame(8'h33, ACT_NONE);
    check("irq_at_thresh", {31'h0, interrupt_request_o}, 32'h1);
    pulse_iret();
    check("irq_serviced", {31'h0, interrupt_request_o}, 32'h0);
    send_frame(8'h44, ACT_NONE);
    check("irq_rearmed", {31'h0, interrupt_request_o}, 32'h1);

    // Push and pop together on a full FIFO.
    send_frame(8'hF0, ACT_READ);
    bus_read(8'h04);
    repeat (4) bus_read(8'h00);

    // Flush coincident with a push.
    send_frame(8'h5A, ACT_NONE);
    send_frame(8'h6B, ACT_NONE);
    send_frame(8'h55, ACT_FLUSH);
    bus_read(8'h04);
    settle_check();

    // Reset while codes are queued and a new code arrives.
    send_frame(8'h01, ACT_NONE);
    send_frame(8'h02, ACT_NONE);
    send_frame(8'h03, ACT_NONE);
    send_frame(8'h04, ACT_RESET);
    bus_read(8'h04);
    bus_read(8'h0C);
    bus_read(8'h08);

    // Randomised mix.
    bus_write(8'h08, 32'h1);
    for (int it = 0; it < 120; it++) begin
      int unsigned sel;
      logic [7:0]  off;
      logic [31:0] d;
      sel = $urandom_range(0, 11);
      off = offs[$urandom_range(0, 9)];
      d   = $urandom();
      case (sel)
        0, 1, 2: send_frame(8'($urandom()), ACT_NONE);
        3:       send_frame(8'($urandom()), ACT_READ);
        4:       send_frame(8'($urandom()), ACT_IRET);
        5, 6:    bus_read(8'h00);
        7:       bus_read(off);
        8: begin
          if (off == 8'h24) d = 32'h1;
          if (off == 8'h0C) d[7:0] = 8'($urandom_range(0, 5));
          bus_write(off, d);
        end
        9:       pulse_iret();
        10:      send_frame(8'($urandom()), ($urandom_range(0, 3) == 0) ? ACT_FLUSH : ACT_NONE);
        default: if ($urandom_range(0, 7) == 0) send_frame(8'($urandom()), ACT_RESET);
                 else bus_read(8'h04);
      endcase
      settle_check();
    end

    repeat (3) @(negedge clk_i);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/ps2_fifo_sb_ctrl.md
PS2_FIFO_SB_CTRL -- requirements
Module: ps2_fifo_sb_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16: scan-code FIFO entries; power of two, 2..256.
REQ-002 SHALL have parameter IRQ_THRESH_RST, default 1: reset value of the THRESH register.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port addr_i, input, 32 bits: bus byte address.
REQ-006 SHALL have port req_i, input, 1 bit: bus request.
REQ-007 SHALL have port write_enable_i, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port write_data_i, input, 32 bits: write data.
REQ-009 SHALL have port read_data_o, output, 32 bits: registered read data.
REQ-010 SHALL have port interrupt_request_o, output, 1 bit: interrupt request to the core.
REQ-011 SHALL have port interrupt_return_i, input, 1 bit: one-cycle pulse from the core on interrupt return.
REQ-012 SHALL have port kclk_i, input, 1 bit: PS/2 clock line.
REQ-013 SHALL have port kdata_i, input, 1 bit: PS/2 data line.

Function
REQ-014 SHALL instantiate PS2Receiver; each keycode_valid pulse is a push of the 8-bit keycode into the FIFO.
REQ-015 SHALL use the register map (byte offsets):
- 0x00 DATA (RO, pop): {24'b0, head code}.
- 0x04 STATUS (RO): bit0 not_empty, bit1 full, bit2 overflow (sticky), bits[15:8] count, other bits 0.
- 0x08 CTRL (RW): bit0 irq_en.
- 0x0C THRESH (RW): bits[7:0].
- 0x24 FLUSH (WO): writing 1 flushes.
REQ-016 SHALL return read data on read_data_o exactly one cycle after the req_i read cycle; read_data_o SHALL hold its value otherwise.
REQ-017 SHALL return 0 for reads of unmapped offsets and of FLUSH; writes to RO or unmapped offsets SHALL have no effect.
REQ-018 SHALL, on a DATA read with count>0, return the head code and pop in that same request cycle; a DATA read when empty SHALL return 0 and not pop.
REQ-019 SHALL, on a push with count==FIFO_DEPTH, drop the code, keep the contents unchanged and set overflow.
REQ-020 SHALL, on a push and a pop in the same cycle, deliver the old head, append the new code and leave count unchanged; this SHALL hold even when the FIFO is full, with no overflow.
REQ-021 SHALL, on a FLUSH write of 1, set count to 0, reset pointers and clear overflow; a push in the same cycle SHALL be discarded.
REQ-022 SHALL treat THRESH==0 as 1; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 SHALL compute pending = irq_en AND count>=max(THRESH,1) AND NOT serviced, and SHALL drive interrupt_request_o from a register loaded with pending (one cycle latency).
REQ-024 SHALL set serviced on interrupt_return_i and clear it on the next accepted push or flush; clearing takes priority when both occur in the same cycle.

Reset
REQ-025 SHALL, with rst_i high at a clk_i edge, set count, pointers, overflow, serviced, read_data_o and interrupt_request_o to 0, irq_en to 0 and THRESH to IRQ_THRESH_RST.
REQ-026 SHALL have reset take priority over every bus and receiver event in the same cycle; FIFO storage contents need not be reset.

Structure
REQ-027 SHALL place the register offsets, STATUS bit positions and the FLUSH key in package ps2_sb_pkg.
REQ-028 SHALL implement storage as one sub-module, sb_sync_fifo (parameters WIDTH and DEPTH; outputs count, full, empty), with the register decode kept in the top.

Verification
REQ-029 SHALL cover: push 0x1C, 0x32, 0x21, then read DATA three times -> 0x1C, 0x32, 0x21; a fourth read -> 0, STATUS=0.
REQ-030 SHALL cover: FIFO_DEPTH=4, push 5 codes -> STATUS bits[15:8]=4 with full=1 and overflow=1; reads return the first 4 codes; the fifth code is lost.
REQ-031 SHALL cover: irq_en=1, THRESH=3, push 2 codes -> irq stays 0; third push -> irq=1 one cycle later; pulse interrupt_return_i -> irq=0; next push -> irq=1.
REQ-032 SHALL cover: full FIFO, simultaneous push 0xF0 and DATA read -> old head returned, count stays 4, overflow stays 0, last entry 0xF0.
REQ-033 SHALL cover: write 1 to 0x24 in the same cycle as a push -> count=0, overflow=0, irq=0.
REQ-034 SHALL cover: assert rst_i mid-burst with 3 codes queued -> STATUS=0, THRESH=IRQ_THRESH_RST, CTRL=0 on the following reads.
